hazard_forward_ctrl: RTL and testbench
======================================

Name: hazard_forward_ctrl

Overview:
- Hazard and forwarding controller for the 16-bit pipeline's decode stage.
- Shadows the destination register, register-write and load flags of the instructions in EXE, MEM and WB.
- Drives the ID-stage ForwardA/ForwardB operand-mux selects, load-use stalls and bubbles, and the IF/ID flush on a taken branch or jump resolved in ID.
- Also provides the register-file write port controls and saturating stall/flush counters.

Parameters:
- R0_ZERO, 1, when 1, register 0 is hardwired zero: never matched for forwarding or hazards.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_ID  in  1  ID holds a real instruction (0 = bubble).
- Ra_ID  in  3  source register A of the ID instruction.
- Rb_ID  in  3  source register B of the ID instruction.
- Rd_ID  in  3  destination register of the ID instruction.
- useA_ID  in  1  ID instruction reads Ra.
- useB_ID  in  1  ID instruction reads Rb.
- RegWr_ID  in  1  ID instruction writes Rd.
- MemRd_ID  in  1  ID instruction is a load.
- branch_taken_ID  in  1  conditional branch resolved taken in ID.
- jump_ID  in  1  unconditional jump, call or return in ID.
- mem_busy  in  1  data memory not ready; freezes the whole pipeline.
- ForwardA  out  2  operand A mux select: 00 = regfile, 01 = EXE ALU result, 10 = MEM writeback data, 11 = WB writeback data.
- ForwardB  out  2  operand B mux select; same encoding as ForwardA.
- stall_PC  out  1  hold the PC.
- stall_IFID  out  1  hold the IF/ID register.
- bubble_EXE  out  1  load a bubble into ID/EXE.
- flush_IFID  out  1  squash the instruction in IF/ID.
- freeze_BACK  out  1  hold ID/EXE, EXE/MEM and MEM/WB.
- WB_en  out  1  register-file write enable.
- WB_dest  out  3  register-file write address.
- stall_count  out  CNT_W  count of load-use stall cycles.
- flush_count  out  CNT_W  count of redirects.

Behaviour:
- Shadow state: EX = {v, rd, rw, mr}; MEM = {v, rd, rw}; WB = {v, rd, rw}.
- Reset cycle clears all v bits and both counters. While reset is high, every output is 0.
- Reset asserted mid-operation discards all in-flight shadow entries. Outputs are 0 on the cycle after reset deasserts, unless ID inputs demand otherwise.
- Advance each cycle with mem_busy=0:
  - WB <= MEM; MEM <= EX.
  - EX <= {valid_ID, Rd_ID, RegWr_ID, MemRd_ID} when no load_use; otherwise EX <= bubble (v=0).
- mem_busy=1: all shadow state holds. freeze_BACK = stall_PC = stall_IFID = 1; bubble_EXE = 0; flush_IFID = 0.
- match(S, r) = S.v & S.rw & (S.rd == r) & !(R0_ZERO & r == 0).
- load_use = valid_ID & EX.mr & ((useA_ID & match(EX, Ra_ID)) | (useB_ID & match(EX, Rb_ID))).
- ForwardA selection, combinational, priority order:
  - 00 if !useA_ID or !valid_ID;
  - else 01 if match(EX, Ra_ID);
  - else 10 if match(MEM, Ra_ID);
  - else 11 if match(WB, Ra_ID);
  - else 00.
- ForwardB: identical selection using useB_ID and Rb_ID.
- Youngest producer wins: EX > MEM > WB.
- WB forwarding covers the same-cycle register-file write; the regfile is not write-through.
- stall_PC = stall_IFID = load_use | mem_busy.
- bubble_EXE = load_use & !mem_busy.
- Load-use stall lasts exactly 1 cycle. Next cycle the load sits in MEM and forwarding selects 10. Two consecutive load_use cycles for the same ID instruction is a bench assertion failure.
- redirect = valid_ID & (branch_taken_ID | jump_ID) & !load_use & !mem_busy.
- flush_IFID = redirect, held for exactly one cycle per redirect.
- A branch or jump coinciding with load_use is deferred. It redirects in the cycle its operands become forwardable, so compare results are only trusted then.
- The redirecting instruction itself still enters EX, so a call's R7 write is tracked.
- WB_en = WB.v & WB.rw; WB_dest = WB.rd.
- stall_count += 1 on each cycle with bubble_EXE; flush_count += 1 on each redirect.
- Both counters saturate at 2^CNT_W − 1 and clear only on reset.
- Latency: all control outputs are combinational from shadow state and current ID inputs, with zero cycles from the ID inputs; shadow state updates one cycle later.

Test Plan:
- Back-to-back ALU: ADD R1 (RegWr, Rd=1), then ID reads Ra=1 → ForwardA=01 same cycle. Next cycle ForwardA=10; cycle after, ForwardA=11; then 00.
- Load-use: LW R2 then ID uses Rb=2 → one cycle of stall_PC=stall_IFID=bubble_EXE=1 with stall_count 0→1. Next cycle: no stall, ForwardB=10.
- Priority: R3 written by instructions in both MEM and WB, ID reads Ra=3 → ForwardA=10. Reading Ra=0 with R0_ZERO=1 while R0 is written in EX → ForwardA=00.
- Taken branch with clear operands → flush_IFID=1 for one cycle, flush_count=1. Same branch behind a load hazard → flush delayed until the cycle after the bubble.
- mem_busy held 3 cycles with R4 pending in EX → shadow unchanged, freeze_BACK=1, bubble_EXE=0, counters unchanged. ForwardA=01 again after release.
- Reset asserted while MEM holds R5 write → next cycle WB_en=0 and ForwardA=00 for Ra=5. Separately, force stall_count to 0xFFFF plus one more stall → stays 0xFFFF.

Source files
------------

// File: rtl/hazard_forward_ctrl.sv
// Decode-stage hazard and forwarding controller for the 16-bit pipeline.
// Tracks the EXE/MEM/WB producers and drives operand forwarding, load-use stalls, redirects and counters.
module hazard_forward_ctrl #(
  parameter bit R0_ZERO = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_ID,
  input  logic [2:0]       Ra_ID,
  input  logic [2:0]       Rb_ID,
  input  logic [2:0]       Rd_ID,
  input  logic             useA_ID,
  input  logic             useB_ID,
  input  logic             RegWr_ID,
  input  logic             MemRd_ID,
  input  logic             branch_taken_ID,
  input  logic             jump_ID,
  input  logic             mem_busy,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             bubble_EXE,
  output logic             flush_IFID,
  output logic             freeze_BACK,
  output logic             WB_en,
  output logic [2:0]       WB_dest,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic             ex_v, ex_rw, ex_mr;
  logic [2:0]       ex_rd;
  logic             mem_v, mem_rw;
  logic [2:0]       mem_rd;
  logic             wb_v, wb_rw;
  logic [2:0]       wb_rd;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic       ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use, redirect;

  function automatic logic match(input logic v, input logic rw, input logic [2:0] rd,
                                 input logic [2:0] r);
    return v && rw && (rd == r) && !(R0_ZERO && (r == 3'd0));
  endfunction

  always_comb begin
    ex_a  = match(ex_v,  ex_rw,  ex_rd,  Ra_ID);
    ex_b  = match(ex_v,  ex_rw,  ex_rd,  Rb_ID);
    mem_a = match(mem_v, mem_rw, mem_rd, Ra_ID);
    mem_b = match(mem_v, mem_rw, mem_rd, Rb_ID);
    wb_a  = match(wb_v,  wb_rw,  wb_rd,  Ra_ID);
    wb_b  = match(wb_v,  wb_rw,  wb_rd,  Rb_ID);

    // Youngest producer wins; WB also covers the same-cycle regfile write.
    fwd_a = 2'b00;
    if (valid_ID && useA_ID) begin
      if (ex_a)       fwd_a = 2'b01;
      else if (mem_a) fwd_a = 2'b10;
      else if (wb_a)  fwd_a = 2'b11;
    end
    fwd_b = 2'b00;
    if (valid_ID && useB_ID) begin
      if (ex_b)       fwd_b = 2'b01;
      else if (mem_b) fwd_b = 2'b10;
      else if (wb_b)  fwd_b = 2'b11;
    end

    load_use = valid_ID && ex_mr && ((useA_ID && ex_a) || (useB_ID && ex_b));
    // A branch behind a load hazard waits until its operands are forwardable.
    redirect = valid_ID && (branch_taken_ID || jump_ID) && !load_use && !mem_busy;
  end

  always_comb begin
    ForwardA    = 2'b00;
    ForwardB    = 2'b00;
    stall_PC    = 1'b0;
    stall_IFID  = 1'b0;
    bubble_EXE  = 1'b0;
    flush_IFID  = 1'b0;
    freeze_BACK = 1'b0;
    WB_en       = 1'b0;
    WB_dest     = 3'd0;
    stall_count = '0;
    flush_count = '0;
    if (!reset) begin
      ForwardA    = fwd_a;
      ForwardB    = fwd_b;
      stall_PC    = load_use || mem_busy;
      stall_IFID  = load_use || mem_busy;
      bubble_EXE  = load_use && !mem_busy;
      flush_IFID  = redirect;
      freeze_BACK = mem_busy;
      WB_en       = wb_v && wb_rw;
      WB_dest     = wb_rd;
      stall_count = stall_cnt;
      flush_count = flush_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v      <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rd     <= 3'd0;
      mem_v     <= 1'b0;
      mem_rw    <= 1'b0;
      mem_rd    <= 3'd0;
      wb_v      <= 1'b0;
      wb_rw     <= 1'b0;
      wb_rd     <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_busy) begin
      wb_v   <= mem_v;
      wb_rw  <= mem_rw;
      wb_rd  <= mem_rd;
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      if (load_use) begin
        ex_v  <= 1'b0;
        ex_rw <= 1'b0;
        ex_mr <= 1'b0;
        ex_rd <= 3'd0;
      end else begin
        ex_v  <= valid_ID;
        ex_rw <= RegWr_ID;
        ex_mr <= MemRd_ID;
        ex_rd <= Rd_ID;
      end
      if (load_use && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (redirect && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus random stimulus
// checked against a queue-of-producers reference model.
module tb_hazard_forward_ctrl;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, valid_ID, useA_ID, useB_ID, RegWr_ID, MemRd_ID, branch_taken_ID, jump_ID, mem_busy;
  logic [2:0] Ra_ID, Rb_ID, Rd_ID;
  logic [1:0] ForwardA, ForwardB;
  logic stall_PC, stall_IFID, bubble_EXE, flush_IFID, freeze_BACK, WB_en;
  logic [2:0] WB_dest;
  logic [CW-1:0] stall_count, flush_count;

  int errors = 0;
  int checks = 0;

  hazard_forward_ctrl #(.R0_ZERO(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_ID(valid_ID), .Ra_ID(Ra_ID), .Rb_ID(Rb_ID), .Rd_ID(Rd_ID),
    .useA_ID(useA_ID), .useB_ID(useB_ID), .RegWr_ID(RegWr_ID), .MemRd_ID(MemRd_ID),
    .branch_taken_ID(branch_taken_ID), .jump_ID(jump_ID), .mem_busy(mem_busy),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .stall_PC(stall_PC), .stall_IFID(stall_IFID),
    .bubble_EXE(bubble_EXE), .flush_IFID(flush_IFID), .freeze_BACK(freeze_BACK),
    .WB_en(WB_en), .WB_dest(WB_dest), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight producers, index 0 = youngest (EX), 2 = oldest (WB).
  typedef struct packed {logic v; logic [2:0] rd; logic rw; logic mr;} ent_t;
  ent_t pipe [3];
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic writes(input int s, input logic [2:0] r);
    return pipe[s].v && pipe[s].rw && pipe[s].rd == r && r != 3'd0;
  endfunction

  function automatic logic [1:0] m_fwd(input logic use_r, input logic [2:0] r);
    if (!valid_ID || !use_r) return 2'd0;
    for (int s = 0; s < 3; s++) if (writes(s, r)) return 2'(s + 1);
    return 2'd0;
  endfunction

  function automatic logic m_lu();
    return valid_ID && pipe[0].mr &&
           ((useA_ID && writes(0, Ra_ID)) || (useB_ID && writes(0, Rb_ID)));
  endfunction

  function automatic logic [20:0] m_outputs();
    logic lu, redir;
    if (reset) return '0;
    lu    = m_lu();
    redir = valid_ID && (branch_taken_ID || jump_ID) && !lu && !mem_busy;
    return {m_fwd(useA_ID, Ra_ID), m_fwd(useB_ID, Rb_ID), lu || mem_busy, lu || mem_busy,
            lu && !mem_busy, redir, mem_busy, pipe[2].v && pipe[2].rw, pipe[2].rd,
            CW'(m_stall), CW'(m_flush)};
  endfunction

  task automatic tick();
    logic lu, redir;
    lu    = m_lu();
    redir = valid_ID && (branch_taken_ID || jump_ID) && !lu && !mem_busy;
    @(posedge clk);
    if (reset) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      m_stall = 0;
      m_flush = 0;
    end else if (!mem_busy) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = lu ? ent_t'('0) : {valid_ID, Rd_ID, RegWr_ID, MemRd_ID};
      if (lu && m_stall < MAXC) m_stall++;
      if (redir && m_flush < MAXC) m_flush++;
    end
    @(negedge clk);
  endtask

  task automatic set_id(input logic v, input logic [2:0] ra, rb, rd,
                        input logic ua, ub, rw, mr, br, jp);
    valid_ID = v; Ra_ID = ra; Rb_ID = rb; Rd_ID = rd; useA_ID = ua; useB_ID = ub;
    RegWr_ID = rw; MemRd_ID = mr; branch_taken_ID = br; jump_ID = jp;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_busy = 1'b0; idle();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [20:0] dut_outputs();
    return {ForwardA, ForwardB, stall_PC, stall_IFID, bubble_EXE, flush_IFID, freeze_BACK,
            WB_en, WB_dest, stall_count, flush_count};
  endfunction

  task automatic test_reset();
    reset = 1'b1; mem_busy = 1'b1;
    set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (dut_outputs() !== 21'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", dut_outputs()); end
    tick();
    reset = 1'b0; mem_busy = 1'b0; idle();
    checks++; if (dut_outputs() !== 21'd0) begin errors++; $display("FAIL post_reset_outputs got=%h exp=0", dut_outputs()); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ForwardA !== 2'b01) begin errors++; $display("FAIL b2b_exe ForwardA got=%b exp=01", ForwardA); end
    tick(); #1;
    checks++; if (ForwardA !== 2'b10) begin errors++; $display("FAIL b2b_mem ForwardA got=%b exp=10", ForwardA); end
    tick(); #1;
    checks++; if (ForwardA !== 2'b11) begin errors++; $display("FAIL b2b_wb ForwardA got=%b exp=11", ForwardA); end
    checks++; if ({WB_en, WB_dest} !== 4'b1_001) begin errors++; $display("FAIL b2b_wbport got=%b exp=1001", {WB_en, WB_dest}); end
    tick(); #1;
    checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL b2b_retired ForwardA got=%b exp=00", ForwardA); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if ({stall_PC, stall_IFID, bubble_EXE} !== 3'b111) begin errors++; $display("FAIL lu_stall got=%b exp=111", {stall_PC, stall_IFID, bubble_EXE}); end
    checks++; if (stall_count !== 4'd0) begin errors++; $display("FAIL lu_count_before got=%0d exp=0", stall_count); end
    tick(); #1;
    checks++; if ({stall_PC, bubble_EXE} !== 2'b00) begin errors++; $display("FAIL lu_release got=%b exp=00", {stall_PC, bubble_EXE}); end
    checks++; if (ForwardB !== 2'b10) begin errors++; $display("FAIL lu_fwd ForwardB got=%b exp=10", ForwardB); end
    checks++; if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count_after got=%0d exp=1", stall_count); end
  endtask

  task automatic test_priority();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, 3'd0, 3'd0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_id(1'b1, 3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ForwardA !== 2'b10) begin errors++; $display("FAIL prio_mem_over_wb got=%b exp=10", ForwardA); end
    set_id(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (ForwardA !== 2'b00) begin errors++; $display("FAIL prio_r0 got=%b exp=00", ForwardA); end
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if (flush_IFID !== 1'b1) begin errors++; $display("FAIL br_flush got=%b exp=1", flush_IFID); end
    tick(); idle();
    checks++; if ({flush_IFID, flush_count} !== {1'b0, 4'd1}) begin errors++; $display("FAIL br_one_shot got=%h exp=01", {flush_IFID, flush_count}); end
    set_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    set_id(1'b1, 3'd2, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++; if ({flush_IFID, bubble_EXE} !== 2'b01) begin errors++; $display("FAIL br_deferred got=%b exp=01", {flush_IFID, bubble_EXE}); end
    tick(); #1;
    checks++; if ({flush_IFID, ForwardA} !== 3'b1_10) begin errors++; $display("FAIL br_after_bubble got=%b exp=110", {flush_IFID, ForwardA}); end
    tick(); idle();
    checks++; if (flush_count !== 4'd2) begin errors++; $display("FAIL br_count got=%0d exp=2", flush_count); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    mem_busy = 1'b1;
    set_id(1'b1, 3'd4, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({freeze_BACK, stall_PC, stall_IFID, bubble_EXE, flush_IFID, ForwardA, stall_count, flush_count} !== {5'b11100, 2'b01, 8'd0}) begin
        errors++; $display("FAIL busy_hold cycle=%0d got=%b", i, {freeze_BACK, stall_PC, stall_IFID, bubble_EXE, flush_IFID, ForwardA, stall_count, flush_count});
      end
      tick(); #1;
    end
    mem_busy = 1'b0; #1;
    checks++; if ({freeze_BACK, ForwardA, flush_IFID} !== 4'b0_01_1) begin errors++; $display("FAIL busy_release got=%b exp=0011", {freeze_BACK, ForwardA, flush_IFID}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1'b1, 3'd0, 3'd0, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    idle(); tick();
    reset = 1'b1; #1; tick();
    reset = 1'b0;
    set_id(1'b1, 3'd5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if ({WB_en, ForwardA} !== 3'b000) begin errors++; $display("FAIL reset_mid got=%b exp=000", {WB_en, ForwardA}); end
    tick(); #1;
    checks++; if ({WB_en, ForwardA} !== 3'b000) begin errors++; $display("FAIL reset_mid_later got=%b exp=000", {WB_en, ForwardA}); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < MAXC + 2; i++) begin
      set_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
      set_id(1'b1, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    idle();
    checks++; if (stall_count !== 4'(MAXC)) begin errors++; $display("FAIL stall_saturate got=%0d exp=%0d", stall_count, MAXC); end
  endtask

  task automatic test_random();
    logic prev_bubble;
    do_reset();
    prev_bubble = 1'b0;
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      set_id($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom), 3'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      checks++;
      if (dut_outputs() !== m_outputs()) begin
        errors++; $display("FAIL rand_outputs cycle=%0d got=%h exp=%h", i, dut_outputs(), m_outputs());
      end
      checks++;
      if (bubble_EXE && prev_bubble) begin
        errors++; $display("FAIL rand_double_bubble cycle=%0d got=1 exp=0", i);
      end
      prev_bubble = bubble_EXE;
      tick();
    end
    reset = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '0;
    reset = 1'b1; mem_busy = 1'b0; idle();
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_branch();
    test_mem_busy();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule
